// File: rtl/counter_run_controller.sv
// counter_run_controller: command sequencer for the counter datapath.
// Accepts START/STOP/PAUSE/RESUME over a valid/ready port, runs a prescaler,
// and produces registered enable/clear/terminal-count strobes for the counter.
module counter_run_controller #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_period,
  input  logic [PRESCALE_W-1:0] cmd_prescale,
  input  logic                  cmd_periodic,
  output logic                  cmd_err,
  output logic                  cnt_en,
  output logic                  cnt_clear,
  output logic [WIDTH-1:0]      qout,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  state_t                  state, state_next;
  logic [WIDTH-1:0]        qout_next;
  logic [PRESCALE_W-1:0]   presc, presc_next;
  logic [WIDTH-1:0]        period_q, period_next;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_next;
  logic                    periodic_q, periodic_next;
  logic                    err_next, en_next, clear_next, tc_next;
  logic                    accept, tick, cmd_taken;

  // Next-state, counter and strobe decode; a legal accepted command pre-empts any tick.
  always_comb begin
    state_next    = state;
    qout_next     = qout;
    presc_next    = presc;
    period_next   = period_q;
    prescale_next = prescale_q;
    periodic_next = periodic_q;
    err_next      = 1'b0;
    en_next       = 1'b0;
    clear_next    = 1'b0;
    tc_next       = 1'b0;
    cmd_taken     = 1'b0;
    accept        = cmd_valid & cmd_ready;
    tick          = (state == RUN) && (presc == prescale_q);

    if (accept) begin
      case (cmd_op)
        OP_START: begin
          if (cmd_period == '0) begin
            err_next = 1'b1;
          end else begin
            cmd_taken     = 1'b1;
            period_next   = cmd_period;
            prescale_next = cmd_prescale;
            periodic_next = cmd_periodic;
            qout_next     = '0;
            presc_next    = '0;
            clear_next    = 1'b1;
            state_next    = RUN;
          end
        end
        OP_STOP: begin
          cmd_taken  = 1'b1;
          qout_next  = '0;
          presc_next = '0;
          clear_next = 1'b1;
          state_next = IDLE;
        end
        OP_PAUSE: begin
          if (state == RUN) begin
            cmd_taken  = 1'b1;
            state_next = PAUSED;
          end else begin
            err_next = 1'b1;
          end
        end
        default: begin
          if (state == PAUSED) begin
            cmd_taken  = 1'b1;
            state_next = RUN;
          end else begin
            err_next = 1'b1;
          end
        end
      endcase
    end

    if (!cmd_taken && state == RUN) begin
      if (tick) begin
        presc_next = '0;
        en_next    = 1'b1;
        if (qout == period_q - WIDTH'(1)) begin
          qout_next = '0;
          tc_next   = 1'b1;
          if (!periodic_q) begin
            state_next = DONE;
          end
        end else begin
          qout_next = qout + WIDTH'(1);
        end
      end else begin
        presc_next = presc + PRESCALE_W'(1);
      end
    end
  end

  // Register state, configuration and every output; reset wins over all activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      qout       <= '0;
      presc      <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      cmd_ready  <= 1'b1;
      cmd_err    <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_clear  <= 1'b0;
      tc         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      qout       <= qout_next;
      presc      <= presc_next;
      period_q   <= period_next;
      prescale_q <= prescale_next;
      periodic_q <= periodic_next;
      cmd_ready  <= ~accept;
      cmd_err    <= err_next;
      cnt_en     <= en_next;
      cnt_clear  <= clear_next;
      tc         <= tc_next;
      busy       <= (state_next == RUN) || (state_next == PAUSED);
      done       <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed testbench for counter_run_controller: a vector table for one-shot,
// error, periodic and collision behaviour, plus hand sequences for pause/resume
// and reset in the middle of a run.
module tb_counter_run_controller;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  typedef struct packed {
    logic [7:0] q;
    logic       tc;
    logic       en;
    logic       clr;
    logic       err;
    logic       rdy;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [1:0] op;
    logic [7:0] period;
    logic [3:0] ps;
    logic       periodic;
    exp_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_period;
  logic [3:0] cmd_prescale;
  logic       cmd_periodic;
  logic       cmd_err;
  logic       cnt_en;
  logic       cnt_clear;
  logic [7:0] qout;
  logic       tc;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  counter_run_controller #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_prescale(cmd_prescale),
    .cmd_periodic(cmd_periodic), .cmd_err(cmd_err), .cnt_en(cnt_en),
    .cnt_clear(cnt_clear), .qout(qout), .tc(tc), .busy(busy), .done(done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic exp_t ex(input logic [7:0] q, input logic t, input logic e,
                              input logic c, input logic r, input logic y,
                              input logic b, input logic d);
    exp_t x;
    x = '{q: q, tc: t, en: e, clr: c, err: r, rdy: y, busy: b, done: d};
    return x;
  endfunction

  function automatic vec_t mk(input logic rst, input logic valid, input logic [1:0] op,
                              input logic [7:0] period, input logic [3:0] ps,
                              input logic periodic, input exp_t e);
    vec_t v;
    v = '{rst: rst, valid: valid, op: op, period: period, ps: ps,
          periodic: periodic, exp: e};
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [1:0] op,
                               input logic [7:0] period, input logic [3:0] ps,
                               input logic periodic);
    @(negedge clk);
    reset        = rst;
    cmd_valid    = valid;
    cmd_op       = op;
    cmd_period   = period;
    cmd_prescale = ps;
    cmd_periodic = periodic;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, OP_START, 8'd0, 4'd0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = '{q: qout, tc: tc, en: cnt_en, clr: cnt_clear, err: cmd_err,
            rdy: cmd_ready, busy: busy, done: done};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s actual q=%0d tc=%b en=%b clr=%b err=%b rdy=%b busy=%b done=%b required q=%0d tc=%b en=%b clr=%b err=%b rdy=%b busy=%b done=%b",
               name, act.q, act.tc, act.en, act.clr, act.err, act.rdy, act.busy, act.done,
               e.q, e.tc, e.en, e.clr, e.err, e.rdy, e.busy, e.done);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_period = '0; cmd_prescale = '0; cmd_periodic = 1'b0;

    // reset, then one-shot P=3 S=0
    vecs.push_back(mk(1, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, OP_START, 3, 0, 0, ex(0, 0, 0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(2, 0, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 1, 1, 0, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 1)));
    // errors and ready handshake
    vecs.push_back(mk(0, 1, OP_PAUSE, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 1, OP_STOP,  0, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, OP_START, 0, 5, 1, ex(0, 0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, OP_PAUSE, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, OP_PAUSE, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 0)));
    // periodic P=2 S=1: tc at 4, 8, 12 edges after accept
    vecs.push_back(mk(0, 1, OP_START, 2, 1, 1, ex(0, 0, 0, 1, 0, 0, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 1, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 1, 1, 0, 0, 1, 1, 0)));
    // RESUME while running is illegal and does not disturb the count
    vecs.push_back(mk(0, 1, OP_RESUME, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 1, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 1, 0, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 1, 0)));
    // STOP on the terminal-tick cycle: tick dropped, no tc
    vecs.push_back(mk(0, 1, OP_STOP,  0, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, OP_START, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 0)));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].period,
                    vecs[i].ps, vecs[i].periodic);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Pause/resume: P=5 S=0, PAUSE lands on the tick after qout=2
    applyStimulus(0, 1, OP_START, 8'd5, 4'd0, 1'b0);
    checkOutput("pr_start", ex(0, 0, 0, 1, 0, 0, 1, 0));
    idle(); checkOutput("pr_q1", ex(1, 0, 1, 0, 0, 1, 1, 0));
    idle(); checkOutput("pr_q2", ex(2, 0, 1, 0, 0, 1, 1, 0));
    applyStimulus(0, 1, OP_PAUSE, 8'd0, 4'd0, 1'b0);
    checkOutput("pr_pause", ex(2, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 10; i++) begin
      idle(); checkOutput($sformatf("pr_hold%0d", i), ex(2, 0, 0, 0, 0, 1, 1, 0));
    end
    applyStimulus(0, 1, OP_RESUME, 8'd0, 4'd0, 1'b0);
    checkOutput("pr_resume", ex(2, 0, 0, 0, 0, 0, 1, 0));
    idle(); checkOutput("pr_q3", ex(3, 0, 1, 0, 0, 1, 1, 0));
    idle(); checkOutput("pr_q4", ex(4, 0, 1, 0, 0, 1, 1, 0));
    idle(); checkOutput("pr_tc", ex(0, 1, 1, 0, 0, 1, 0, 1));

    // Reset mid-run at qout=4, then no activity until a new START
    applyStimulus(0, 1, OP_START, 8'd8, 4'd0, 1'b1);
    checkOutput("rs_start", ex(0, 0, 0, 1, 0, 0, 1, 0));
    for (int i = 1; i <= 4; i++) begin
      idle(); checkOutput($sformatf("rs_q%0d", i), ex(8'(i), 0, 1, 0, 0, 1, 1, 0));
    end
    applyStimulus(1, 0, OP_START, 8'd0, 4'd0, 1'b0);
    checkOutput("rs_reset", ex(0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 20; i++) begin
      idle(); checkOutput($sformatf("rs_quiet%0d", i), ex(0, 0, 0, 0, 0, 1, 0, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
